// File: rtl/spi_rx_slave_if.sv
// SPI pin bundle plus the received-word valid/ready stream of spi_rx_slave.
// The receiver uses the slave modport and the pin driver / consumer uses master.
interface spi_rx_slave_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              mosi;
    logic              ss;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_overrun;
    logic              rx_abort;
    logic              busy;

    modport slave (
        input  sclk, mosi, ss, rx_ready,
        output rx_data, rx_valid, rx_overrun, rx_abort, busy
    );

    modport master (
        output sclk, mosi, ss, rx_ready,
        input  rx_data, rx_valid, rx_overrun, rx_abort, busy
    );
endinterface

// File: rtl/spi_rx_slave.sv
// SPI receive slave: synchronizes sclk/mosi/ss into clk, rebuilds DATA_W-bit words.
// Optional build macro SPI_RX_ERRCNT_EN adds err_clr / err_cnt (saturating overrun+abort count).
//
//  state | meaning
//  IDLE  | ss low, sclk edges ignored
//  RECV  | frame open, shifting a bit in on every synchronized sclk rise
module spi_rx_slave #(
    parameter int DATA_W      = 8,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    spi_rx_slave_if.slave   bus
`ifdef SPI_RX_ERRCNT_EN
    ,
    input  logic            err_clr,
    output logic [7:0]      err_cnt
`endif
);
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t              state, state_n;
    logic [SYNC_N-1:0]   sclk_sync, mosi_sync, ss_sync;
    logic                sclk_d;
    logic                sclk_s, mosi_s, ss_s, sclk_rise;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]   shift, shift_n, shift_in;
    logic                word_done, abort_n;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q, rx_overrun_q, rx_abort_q;

    assign sclk_s    = sclk_sync[SYNC_N-1];
    assign mosi_s    = mosi_sync[SYNC_N-1];
    assign ss_s      = ss_sync[SYNC_N-1];
    assign sclk_rise = sclk_s & ~sclk_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_N-2:0], bus.sclk};
            mosi_sync <= {mosi_sync[SYNC_N-2:0], bus.mosi};
            ss_sync   <= {ss_sync[SYNC_N-2:0], bus.ss};
            sclk_d    <= sclk_s;
        end
    end

    always_comb begin
        if (LSB_FIRST) shift_in = {mosi_s, shift[DATA_W-1:1]};
        else           shift_in = {shift[DATA_W-2:0], mosi_s};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        word_done = 1'b0;
        abort_n   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_s) begin
                    state_n   = RECV;
                    bit_cnt_n = '0;
                end
            end
            RECV: begin
                if (sclk_rise) begin
                    shift_n = shift_in;
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt_n = '0;
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                // A bit arriving with the ss fall is counted before deciding on abort.
                if (!ss_s) begin
                    state_n   = IDLE;
                    abort_n   = (bit_cnt_n != '0);
                    bit_cnt_n = '0;
                    shift_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_abort_q   <= 1'b0;
        end else begin
            rx_overrun_q <= 1'b0;
            rx_abort_q   <= abort_n;
            if (word_done) begin
                if (!rx_valid_q || bus.rx_ready) begin
                    rx_data_q  <= shift_in;
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_overrun = rx_overrun_q;
    assign bus.rx_abort   = rx_abort_q;
    assign bus.busy       = (state == RECV);

`ifdef SPI_RX_ERRCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= 8'h00;
        end else if (err_clr) begin
            err_cnt <= 8'h00;
        end else if ((rx_overrun_q || rx_abort_q) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif
endmodule
